// File: rtl/bitstream_byte_feeder_pkg.sv
// Shared constants for the CABAC byte feeder and its FIFO.
package cabac_pkg;
  localparam int          BYTE_W       = 8;
  localparam logic [7:0]  EPB_BYTE     = 8'h03;
  localparam logic [7:0]  PAD_BYTE     = 8'h00;
  localparam int          ZERO_RUN_MAX = 2;
endpackage

// File: rtl/bitstream_byte_feeder_if.sv
// Stream-side (valid/ready) and decoder-side (request/data) signals of the feeder.
interface bitstream_byte_feeder_if;
  import cabac_pkg::*;
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              request_byte;
  logic [BYTE_W-1:0] data;
  logic              data_valid;
  logic              stall;

  modport slave (
    input  in_data, in_valid, in_last, request_byte,
    output in_ready, data, data_valid, stall
  );
  modport master (
    output in_data, in_valid, in_last, request_byte,
    input  in_ready, data, data_valid, stall
  );
endinterface

// File: rtl/bitstream_byte_feeder_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers, occupancy, synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level
);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  a_level_bound: assert property (@(posedge clk) disable iff (reset) level <= FULL);
  a_no_underflow: assert property (@(posedge clk) disable iff (reset || clear) !(pop && level == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset || clear) !(push && !pop && level == FULL));
endmodule

// File: rtl/bitstream_byte_feeder.sv
// Byte feeder for the CABAC decoder: strips emulation-prevention bytes, buffers,
// and hands bytes out on request, padding with zeros once the slice is exhausted.
module bitstream_byte_feeder
  import cabac_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit EPB_REMOVE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  bitstream_byte_feeder_if.slave bus,
  output logic                   eos,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             epb_count
);
  localparam int              LW     = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]   FULL   = LW'(DEPTH);
  localparam logic [1:0]      ZR_MAX = 2'(ZERO_RUN_MAX);

  logic [1:0]        zero_run;
  logic              last_seen;
  logic              accept;
  logic              is_epb;
  logic              push;
  logic              pop;
  logic [BYTE_W-1:0] head;

  // Handshake, EPB detection and decoder-side outputs from registered state.
  always_comb begin
    bus.in_ready   = (level < FULL) && !last_seen && !start;
    accept         = bus.in_valid && bus.in_ready;
    is_epb         = EPB_REMOVE && (zero_run == ZR_MAX) && (bus.in_data == EPB_BYTE);
    push           = accept && !is_epb;
    pop            = bus.request_byte && (level != '0) && !start;
    bus.data       = (level != '0) ? head : PAD_BYTE;
    bus.data_valid = (level != '0) || eos;
    bus.stall      = bus.request_byte && !bus.data_valid;
  end

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .push    (push),
    .wr_data (bus.in_data),
    .pop     (pop),
    .rd_data (head),
    .level   (level)
  );

  // Zero-run tracking, slice-end latch, sticky eos and saturating EPB counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_run  <= '0;
      last_seen <= 1'b0;
      eos       <= 1'b0;
      epb_count <= '0;
    end else if (start) begin
      zero_run  <= '0;
      last_seen <= 1'b0;
      eos       <= 1'b0;
      epb_count <= '0;
    end else begin
      eos <= eos || (last_seen && level == '0);
      if (accept) begin
        if (is_epb) begin
          zero_run <= '0;
          if (epb_count != 8'hFF) epb_count <= epb_count + 8'd1;
        end else if (bus.in_data == 8'h00) begin
          zero_run <= (zero_run == ZR_MAX) ? ZR_MAX : zero_run + 2'd1;
        end else begin
          zero_run <= '0;
        end
        // A final byte ends the run regardless of its value.
        if (bus.in_last) begin
          last_seen <= 1'b1;
          zero_run  <= '0;
        end
      end
    end
  end
endmodule

// File: doc/bitstream_byte_feeder.md
Name: bitstream_byte_feeder

Overview:
Upstream byte source for the CABAC bypass/bin decoder. It accepts raw slice-data bytes from the NAL/stream interface with a valid/ready handshake. It strips emulation-prevention bytes (0x00 0x00 0x03 → 0x00 0x00) and buffers the result in a small FIFO. It then presents one byte on `data`, consumed on the decoder's `request_byte`, and pads with 0x00 after end of slice.

Parameters:
DEPTH, 4, FIFO depth in bytes; power of 2, ≥2.
EPB_REMOVE, 1, 1 = drop emulation-prevention bytes; 0 = pass every byte through unchanged.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  synchronous one-cycle pulse: flush FIFO, clear eos/zero-run/counters for a new slice
in_data  input  8  raw stream byte
in_valid  input  1  in_data valid
in_last  input  1  in_data is the final byte of slice data; qualified by in_valid
in_ready  output  1  feeder can accept in_data this cycle
request_byte  input  1  decoder consumes `data` at this rising edge
data  output  8  byte offered to decoder
data_valid  output  1  `data` is meaningful (FIFO non-empty or eos padding)
stall  output  1  request_byte high while data_valid low; decoder must hold state
eos  output  1  in_last byte accepted and FIFO drained
level  output  $clog2(DEPTH)+1  current FIFO occupancy
epb_count  output  8  emulation-prevention bytes removed since start/reset; saturates at 255

Behaviour:
- Reset (async), all registered state cleared:
  - FIFO empty, level=0, zero_run=0, last_seen=0, eos=0, epb_count=0.
  - Outputs therefore: in_ready=1, data_valid=0, data=0x00, stall=request_byte.
- `start` has priority over every other event in the same cycle and produces the same state as reset.
  - While start=1: in_ready=0, and no push or pop occurs.
- Accept condition:
  - A byte is accepted when in_valid && in_ready.
  - in_ready = (level < DEPTH) && !last_seen && !start. A pop in the same cycle does not raise in_ready.
- EPB filter, applied to each accepted byte:
  - zero_run is 2 bits, saturating at 2.
  - If EPB_REMOVE && zero_run==2 && in_data==0x03: the byte is not written; zero_run←0; epb_count←sat(epb_count+1).
  - Else the byte is written at the tail. If in_data==0x00, zero_run←min(zero_run+1,2); otherwise zero_run←0.
  - in_data==0x03 when zero_run<2 is written normally.
  - A 0x03 following 0x00 0x00 0x03 is written; zero_run was cleared by the removal.
- in_last on an accepted byte sets last_seen, even when that byte is an EPB and is dropped. zero_run←0.
- Read side, combinational from registered state:
  - data = FIFO head when level>0, else 0x00.
  - data_valid = (level>0) || eos.
  - stall = request_byte && !data_valid.
- Pop: on a rising edge with request_byte && level>0, the head advances.
  - request_byte while eos (FIFO empty) returns 0x00 with no state change; padding is unlimited.
  - request_byte while stalled has no effect.
- Simultaneous push and pop: level is unchanged and the written byte lands behind the head.
  - With level==1, the popped byte is the old head; the new byte becomes the head next cycle.
- eos ← last_seen && level==0, registered.
  - eos asserts the cycle after the final pop, or the cycle after acceptance if the FIFO was already empty.
  - eos stays asserted until start or reset.
- Latency:
  - A byte accepted at edge N is visible on `data` after edge N if the FIFO was empty.
  - Zero bubbles: one byte per cycle sustained in and out.
- Pointers wrap modulo DEPTH. level never exceeds DEPTH and never underflows (assertion-checked).
- Reset mid-stream: buffered bytes are discarded and no partial state survives.

Decomposition:
- Shared package cabac_pkg:
  - EPB_BYTE = 8'h03
  - ZERO_RUN_MAX = 2
  - PAD_BYTE = 8'h00
  - BYTE_W = 8
- Sub-module sync_fifo holds storage, pointers, level and push/pop. Parameters: WIDTH, DEPTH. Inputs: clk, reset, clear.
- The top level holds the EPB filter, the last/eos logic and the decoder-side handshake.

Test Plan:
- Reset, then push 0x8C 0xD1 with request_byte low → level=2, data=0x8C, in_ready=1. Assert request_byte 1 cycle → data=0xD1, level=1.
- Push 0x00 0x00 0x03 0x01 → FIFO holds 0x00 0x00 0x01, epb_count=1. Repeat with EPB_REMOVE=0 → 4 bytes held, epb_count=0.
- Push 0x00 0x00 0x03 0x03 → FIFO holds 0x00 0x00 0x03. Push 0x00 0x03 → both written, epb_count unchanged.
- Fill DEPTH=4 bytes → in_ready=0; next cycle push+pop asserted → push refused that cycle, level=3 after the edge. Continuous push+pop thereafter → level constant, bytes in order.
- request_byte with level=0, no in_last → stall=1, data_valid=0, level stays 0. Accept byte 0x5A with in_last → decoder pops 0x5A; next cycle eos=1; further requests → data=0x00, stall=0.
- Mid-stream: level=3 and last_seen=1 → start pulse (or async reset) → level=0, eos=0, epb_count=0, in_ready=1 next cycle.
